cache_ctrl: RTL

Miss-handling controller for the 2-line, 4-word-block direct-mapped data cache.
- Sits between the CPU load/store port, the cache arrays and main memory.
- Detects misses, stalls the pipeline, writes back a dirty victim block word-by-word, then refills the requested block over a req/ack memory handshake.
- On hits it is transparent: the cache serves the access in the same cycle with no stall.

---
 rtl/cache_ctrl_if.sv | 48 ++++
 rtl/cache_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if
//   The bundle of signals between the miss controller, the CPU load/store port,
//   the cache arrays and main memory.
//   master : the miss controller (cache_ctrl). It drives stall, the writeback
//            word select, the refill strobes and the memory request.
//   slave  : the environment. It drives the CPU request, the cache lookup
//            results, the victim data and the memory response.
interface cache_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 27
);
    // CPU port
    logic                  cpu_rd_en;
    logic                  cpu_wr_en;
    logic [DATA_WIDTH-1:0] cpu_addr;
    logic                  stall;
    // cache arrays
    logic                  c_hit;
    logic                  c_dirty;
    logic [TAG_WIDTH-1:0]  c_victim_tag;
    logic [1:0]            wb_word;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  fill_en;
    logic [1:0]            fill_word;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  fill_done;
    // main memory
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  cpu_rd_en, cpu_wr_en, cpu_addr, c_hit, c_dirty, c_victim_tag,
               wb_data, mem_ack, mem_rdata,
        output stall, wb_word, fill_en, fill_word, fill_data, fill_done,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_rd_en, cpu_wr_en, cpu_addr, c_hit, c_dirty, c_victim_tag,
               wb_data, mem_ack, mem_rdata,
        input  stall, wb_word, fill_en, fill_word, fill_data, fill_done,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl
//   Miss-handling controller for a 2-line, 4-word-block direct-mapped data
//   cache. Hits pass through with no stall. A miss stalls the CPU, writes a
//   dirty victim back word by word, refills the requested block over a req/ack
//   memory handshake, then pulses fill_done so the cache can set tag/valid.
//
// Ports
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : cache_ctrl_if.master (CPU port, cache array port, memory port)
//   hit_count, miss_count : performance counters, present only when the
//              CACHE_CTRL_PERF_EN macro is defined
//
// Optional feature macro: CACHE_CTRL_PERF_EN
module cache_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 4,
    parameter int TAG_WIDTH  = 27
) (
    input  logic         clk,
    input  logic         rst,
    cache_ctrl_if.master bus
`ifdef CACHE_CTRL_PERF_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);
    localparam logic [1:0] LAST_K = 2'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} state_t;

    state_t                 state;
    logic [1:0]             k;
    // Only the block address of the miss is kept; the byte/word offset is
    // replaced by k when forming memory addresses.
    logic [DATA_WIDTH-1:4]  miss_hi;
    logic [TAG_WIDTH-1:0]   victim_tag;

    logic access, miss, last;
    assign access = bus.cpu_rd_en | bus.cpu_wr_en;
    assign miss   = (state == IDLE) & access & ~bus.c_hit;
    assign last   = (k == LAST_K);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            miss_hi    <= '0;
            victim_tag <= '0;
        end else begin
            case (state)
                IDLE: if (miss) begin
                    miss_hi    <= bus.cpu_addr[DATA_WIDTH-1:4];
                    victim_tag <= bus.c_victim_tag;
                    k          <= '0;
                    state      <= bus.c_dirty ? WRITEBACK : REFILL;
                end
                // k+1 wraps 3 -> 0 exactly on the leaving transition.
                WRITEBACK: if (bus.mem_ack) begin
                    k <= k + 2'd1;
                    if (last) state <= REFILL;
                end
                REFILL: if (bus.mem_ack) begin
                    k <= k + 2'd1;
                    if (last) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from the registered state and k. stall and the
    // refill strobes also see live inputs, so everything is gated by rst to
    // keep all outputs low while reset is held.
    always_comb begin
        bus.stall     = 1'b0;
        bus.wb_word   = '0;
        bus.fill_en   = 1'b0;
        bus.fill_word = '0;
        bus.fill_data = '0;
        bus.fill_done = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (!rst) begin
            bus.stall = (state != IDLE) | (access & ~bus.c_hit);
            case (state)
                WRITEBACK: begin
                    bus.mem_req   = 1'b1;
                    bus.mem_we    = 1'b1;
                    // Victim shares the miss set index; only the tag differs.
                    bus.mem_addr  = {victim_tag, miss_hi[4], k, 2'b00};
                    bus.wb_word   = k;
                    bus.mem_wdata = bus.wb_data;
                end
                REFILL: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_addr = {miss_hi, k, 2'b00};
                    if (bus.mem_ack) begin
                        bus.fill_en   = 1'b1;
                        bus.fill_word = k;
                        bus.fill_data = bus.mem_rdata;
                    end
                end
                DONE: bus.fill_done = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CACHE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && access && bus.c_hit) hit_count <= hit_count + 32'd1;
            if (miss) miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule
